// File: rtl/fifo_write_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_write_arbiter
//
// Round-robin arbiter sharing the single write port of a 16-entry FIFO between
// two valid/ready producers. Ownership is granted in bursts of up to MAX_BURST
// beats. Writes are gated by fifo_full. Ownership moves directly between the two
// owners, so a handoff costs no idle cycle.
//
// Parameters
//   DATA_WIDTH  width of requester and FIFO data
//   MAX_BURST   max consecutive beats per owner while the other waits (1..255)
//
// Ports
//   clk              system clock, rising edge
//   reset            asynchronous active-low reset
//   req0_valid/data  requester 0 beat offer
//   req0_ready       requester 0 beat accepted this cycle
//   req1_valid/data  requester 1 beat offer
//   req1_ready       requester 1 beat accepted this cycle
//   fifo_full        FIFO full flag
//   fifo_write_en    FIFO write strobe
//   fifo_write_data  FIFO write data
//   grant            one-hot current owner (bit0 = req0, bit1 = req1), 0 if idle
// -----------------------------------------------------------------------------
module fifo_write_arbiter #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned MAX_BURST  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0_valid,
    input  logic [DATA_WIDTH-1:0] req0_data,
    output logic                  req0_ready,
    input  logic                  req1_valid,
    input  logic [DATA_WIDTH-1:0] req1_data,
    output logic                  req1_ready,
    input  logic                  fifo_full,
    output logic                  fifo_write_en,
    output logic [DATA_WIDTH-1:0] fifo_write_data,
    output logic [1:0]            grant
);

    localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);

    // One-hot encoding lets grant be the state register itself.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        OWN0 = 2'b01,
        OWN1 = 2'b10
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             last_owner;
    logic             last_owner_nxt;
    logic [CNT_W-1:0] beat_cnt;
    logic [CNT_W-1:0] beat_cnt_nxt;

    logic             own_valid;
    logic             other_valid;
    logic             xfer;
    logic             burst_done;
    logic             release_own;

    // Owner-relative view of the requesters.
    always_comb begin
        own_valid   = 1'b0;
        other_valid = 1'b0;
        case (state)
            OWN0: begin
                own_valid   = req0_valid;
                other_valid = req1_valid;
            end
            OWN1: begin
                own_valid   = req1_valid;
                other_valid = req0_valid;
            end
            default: begin
                own_valid   = 1'b0;
                other_valid = 1'b0;
            end
        endcase
    end

    // Full stalls the owner but never forces a release.
    assign xfer        = (state != IDLE) && own_valid && !fifo_full;
    assign burst_done  = xfer && (beat_cnt == LAST_BEAT);
    assign release_own = (state != IDLE) && (!own_valid || burst_done);

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            last_owner <= 1'b1;
            beat_cnt   <= '0;
        end else begin
            state      <= state_nxt;
            last_owner <= last_owner_nxt;
            beat_cnt   <= beat_cnt_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt      = state;
        last_owner_nxt = last_owner;
        beat_cnt_nxt   = beat_cnt;
        case (state)
            IDLE: begin
                // On a tie the requester that did not own last wins.
                if (req0_valid && req1_valid) begin
                    state_nxt = last_owner ? OWN0 : OWN1;
                end else if (req0_valid) begin
                    state_nxt = OWN0;
                end else if (req1_valid) begin
                    state_nxt = OWN1;
                end
            end
            OWN0, OWN1: begin
                if (release_own) begin
                    last_owner_nxt = (state == OWN1);
                    beat_cnt_nxt   = '0;
                    if (other_valid) begin
                        state_nxt = (state == OWN0) ? OWN1 : OWN0;
                    end else if (own_valid) begin
                        // Burst limit hit with nobody waiting: start a fresh burst.
                        state_nxt = state;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else if (xfer) begin
                    beat_cnt_nxt = beat_cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Write-port steering, combinational from the registered owner.
    always_comb begin
        req0_ready      = 1'b0;
        req1_ready      = 1'b0;
        fifo_write_en   = 1'b0;
        fifo_write_data = '0;
        case (state)
            OWN0: begin
                req0_ready      = !fifo_full;
                fifo_write_en   = req0_valid && !fifo_full;
                fifo_write_data = req0_data;
            end
            OWN1: begin
                req1_ready      = !fifo_full;
                fifo_write_en   = req1_valid && !fifo_full;
                fifo_write_data = req1_data;
            end
            default: begin
                req0_ready      = 1'b0;
                req1_ready      = 1'b0;
                fifo_write_en   = 1'b0;
                fifo_write_data = '0;
            end
        endcase
    end

    assign grant = 2'(state);

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fifo_write_arbiter
//
// Drives two producers and a 16-entry FIFO occupancy model around the arbiter
// and compares every cycle against an integer-level ownership model.
// -----------------------------------------------------------------------------
module tb_fifo_write_arbiter;

    localparam int unsigned DATA_WIDTH = 8;
    localparam int unsigned MAX_BURST  = 4;
    localparam int          FIFO_DEPTH = 16;

    logic                  clk;
    logic                  reset;
    logic                  req0_valid;
    logic [DATA_WIDTH-1:0] req0_data;
    logic                  req0_ready;
    logic                  req1_valid;
    logic [DATA_WIDTH-1:0] req1_data;
    logic                  req1_ready;
    logic                  fifo_full;
    logic                  fifo_write_en;
    logic [DATA_WIDTH-1:0] fifo_write_data;
    logic [1:0]            grant;

    fifo_write_arbiter #(
        .DATA_WIDTH(DATA_WIDTH),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .req0_valid     (req0_valid),
        .req0_data      (req0_data),
        .req0_ready     (req0_ready),
        .req1_valid     (req1_valid),
        .req1_data      (req1_data),
        .req1_ready     (req1_ready),
        .fifo_full      (fifo_full),
        .fifo_write_en  (fifo_write_en),
        .fifo_write_data(fifo_write_data),
        .grant          (grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Producer state: vld/dat are what is offered; want is the directed intent.
    logic [DATA_WIDTH-1:0] dat [2];
    logic                  vld [2];
    bit                    want[2];
    bit                    rand_mode = 0;
    bit                    rd_en     = 1;
    int                    fcnt      = 0;
    logic [DATA_WIDTH-1:0] wr_log[$];

    // Reference model: who owns the port, who owned last, beats done this burst.
    int m_owner = -1;
    int m_last  = 1;
    int m_beats = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_last  = 1;
        m_beats = 0;
    endtask

    // One clock cycle: drive, check against model, then advance model and producers.
    task automatic run_cycle(input bit pulse_rst = 0);
        logic                  full;
        logic [1:0]            e_grant;
        logic                  e_rdy[2];
        logic                  e_we;
        logic [DATA_WIDTH-1:0] e_wd;
        bit                    tr[2];
        bit                    rd;
        int                    k;
        int                    o;

        @(negedge clk);
        full       = (fcnt == FIFO_DEPTH);
        req0_valid = vld[0];
        req0_data  = dat[0];
        req1_valid = vld[1];
        req1_data  = dat[1];
        fifo_full  = full;
        if (pulse_rst) begin
            #1 reset = 1'b0;
            model_reset();
        end
        #1;

        e_grant = (m_owner == 0) ? 2'b01 : (m_owner == 1) ? 2'b10 : 2'b00;
        for (int i = 0; i < 2; i++) begin
            e_rdy[i] = (m_owner == i) && !full;
            tr[i]    = e_rdy[i] && vld[i];
        end
        e_we = tr[0] || tr[1];
        e_wd = (m_owner == 0) ? dat[0] : (m_owner == 1) ? dat[1] : '0;

        check_eq("grant", 32'(grant), 32'(e_grant));
        check_eq("req0_ready", 32'(req0_ready), 32'(e_rdy[0]));
        check_eq("req1_ready", 32'(req1_ready), 32'(e_rdy[1]));
        check_eq("write_en", 32'(fifo_write_en), 32'(e_we));
        check_eq("write_data", 32'(fifo_write_data), 32'(e_wd));
        if (fifo_write_en === 1'b1) wr_log.push_back(fifo_write_data);

        if (pulse_rst) reset = 1'b1;

        // Ownership model for the coming edge.
        if (m_owner < 0) begin
            if (vld[0] && vld[1]) m_owner = 1 - m_last;
            else if (vld[0])      m_owner = 0;
            else if (vld[1])      m_owner = 1;
        end else begin
            k = m_owner;
            o = 1 - k;
            if (tr[k]) m_beats++;
            if (!vld[k] || (tr[k] && m_beats == MAX_BURST)) begin
                m_last  = k;
                m_beats = 0;
                if (vld[o])      m_owner = o;
                else if (vld[k]) m_owner = k;
                else             m_owner = -1;
            end
        end

        // FIFO occupancy.
        rd = (rand_mode ? ($urandom_range(99) < 45) : rd_en) && (fcnt > 0);
        fcnt = fcnt + (e_we ? 1 : 0) - (rd ? 1 : 0);

        // Producers: data held until accepted, valid only changes after a transfer or while low.
        for (int i = 0; i < 2; i++) begin
            if (tr[i]) begin
                dat[i] = dat[i] + 8'd1;
                vld[i] = rand_mode ? ($urandom_range(3) != 0) : want[i];
            end else if (!vld[i]) begin
                vld[i] = rand_mode ? ($urandom_range(1) == 1) : want[i];
            end
        end
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) run_cycle();
    endtask

    initial begin
        logic [DATA_WIDTH-1:0] e_seq;

        reset      = 1'b0;
        req0_valid = 1'b0;
        req0_data  = '0;
        req1_valid = 1'b0;
        req1_data  = '0;
        fifo_full  = 1'b0;
        vld[0] = 1'b0; vld[1] = 1'b0;
        dat[0] = 8'h00; dat[1] = 8'h80;
        want[0] = 0; want[1] = 0;

        // Reset: everything quiet.
        repeat (2) @(negedge clk);
        #1;
        check_eq("rst_grant", 32'(grant), 32'd0);
        check_eq("rst_ready0", 32'(req0_ready), 32'd0);
        check_eq("rst_ready1", 32'(req1_ready), 32'd0);
        check_eq("rst_we", 32'(fifo_write_en), 32'd0);
        check_eq("rst_wd", 32'(fifo_write_data), 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // Tie from reset goes to req0, then bursts alternate with no bubbles.
        want[0] = 1; want[1] = 1; rd_en = 1;
        wr_log.delete();
        run_cycles(14);
        for (int i = 0; i < 9; i++) begin
            e_seq = (i < 4) ? 8'(i) : (i < 8) ? 8'(8'h80 + i - 4) : 8'(i - 4);
            check_eq($sformatf("burst_seq%0d", i),
                     (i < wr_log.size()) ? 32'(wr_log[i]) : 32'hFFFF_FFFF, 32'(e_seq));
        end

        // Fill through req1 with no reads, then let reads resume.
        want[0] = 0; rd_en = 0;
        run_cycles(32);
        @(posedge clk); #1;
        check_eq("stall_we", 32'(fifo_write_en), 32'd0);
        check_eq("stall_ready1", 32'(req1_ready), 32'd0);
        rd_en = 1;
        run_cycles(6);

        // Drain to idle.
        want[1] = 0;
        run_cycles(30);

        // req0 owns last, then a tie must go to req1.
        want[0] = 1;
        run_cycles(2);
        want[0] = 0;
        run_cycles(4);
        want[0] = 1; want[1] = 1;
        run_cycles(2);
        @(posedge clk); #1;
        check_eq("tie_after_req0", 32'(grant), 32'b10);
        run_cycles(10);

        // Drain, then reset in the middle of a req1 burst.
        want[0] = 0; want[1] = 0;
        run_cycles(30);
        want[1] = 1;
        run_cycles(2);
        @(posedge clk); #1;
        check_eq("own1_before_rst", 32'(grant), 32'b10);
        want[0] = 1;
        run_cycle();
        run_cycle(1);
        @(posedge clk); #1;
        check_eq("tie_after_rst", 32'(grant), 32'b01);
        run_cycles(10);

        // Randomised traffic with frequent full stalls.
        rand_mode = 1;
        run_cycles(3000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_write_arbiter.md
# fifo_write_arbiter

Round-robin arbiter that shares the single write port of the 16-entry `fifo` between two independent producers. Each producer uses a valid/ready handshake. The arbiter grants ownership of the write port in bursts of up to `MAX_BURST` beats and gates writes on `fifo_full`. It sits directly in front of the `fifo` write side; the read side is untouched.

## Interface
- `DATA_WIDTH`, 8: width of requester and FIFO data.
- `MAX_BURST`, 4: maximum consecutive beats one owner may transfer while the other requester waits; legal range 1..255.
- `clk`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-low reset (asserted when 0).
- `req0_valid`  in  1  requester 0 has a beat.
- `req0_data`  in  DATA_WIDTH  requester 0 beat data.
- `req0_ready`  out  1  requester 0 beat accepted this cycle.
- `req1_valid`  in  1  requester 1 has a beat.
- `req1_data`  in  DATA_WIDTH  requester 1 beat data.
- `req1_ready`  out  1  requester 1 beat accepted this cycle.
- `fifo_full`  in  1  from `fifo.full`.
- `fifo_write_en`  out  1  to `fifo.write_en`.
- `fifo_write_data`  out  DATA_WIDTH  to `fifo.write_data`.
- `grant`  out  2  one-hot current owner (bit0 = req0, bit1 = req1); 0 when idle.

## Operation
- State machine: IDLE, OWN0, OWN1. Registers:
  - `state`;
  - `last_owner`, 1 bit;
  - `beat_cnt`, width `$clog2(MAX_BURST+1)`.
- Handshake per requester: once `valid` is raised, `data` must stay stable until `ready`. A transfer occurs in a cycle where `valid && ready`.
- Write-port outputs are combinational from registered state:
  - In OWNk: `reqk_ready = !fifo_full`, `fifo_write_en = reqk_valid && !fifo_full`, `fifo_write_data = reqk_data`.
  - In IDLE: both readies 0, `fifo_write_en` 0, `fifo_write_data` 0.
  - The non-owner's `ready` is always 0.
- IDLE:
  - If exactly one valid, go to that owner.
  - If both valid, go to the requester other than `last_owner`.
  - No transfer happens in IDLE (one-cycle grant latency).
- OWNk, evaluated at each edge:
  - On a transfer, `beat_cnt` increments.
  - **Release** happens if `reqk_valid` is low, or if a transfer occurs with `beat_cnt == MAX_BURST-1`.
  - On release: `last_owner` becomes k and `beat_cnt` becomes 0. Next state is OWN(other) if the other's valid is high, otherwise IDLE.
  - Exception: if the release is due to the burst limit, the other is not valid, and `reqk_valid` is high, stay in OWNk with `beat_cnt` = 0.
- Ownership moves directly between OWN0 and OWN1 with no IDLE bubble.
- `fifo_full` stalls the owner: no transfer and `beat_cnt` holds. Ownership is not released due to full.
- Per-requester ordering is preserved; beats are never duplicated or dropped.

## Timing
- Reset (`reset` = 0), asynchronous: `state` = IDLE, `last_owner` = 1 (req0 wins the first tie), `beat_cnt` = 0. All outputs are 0 during and immediately after reset.
- Latency from `valid` rising in IDLE to first `ready` is 1 cycle. Steady-state throughput is 1 beat per cycle, including across an ownership handoff.
- `fifo_write_en` is high only in cycles where `fifo_full` is low. The FIFO's `full` rises the cycle after its 16th write, so no overflow write is issued.
- Combinational paths (`valid`/`data`/`fifo_full` to outputs) must not feed back into requester `valid` within the same cycle.
- Reset mid-burst: `state` returns to IDLE immediately. A beat in flight is not accepted.
- `grant` equals the registered state and changes only on a clock edge.

## Test plan
- **Reset/idle:** hold `reset` low, all inputs 0 -> every output 0. Release reset, raise `req0_valid` with data 0xA5 -> the next cycle shows `grant`=01, `req0_ready`=1, `fifo_write_en`=1, `fifo_write_data`=0xA5; FIFO `empty` deasserts after that edge.
- **Burst alternation:** both valid continuously, req0 sends 0x00.., req1 sends 0x80.., `MAX_BURST`=4 -> FIFO receives 00,01,02,03,80,81,82,83,04,... with no idle write cycles after the first grant.
- **Full stall:** fill the FIFO to 16 entries through req1 -> `fifo_full`=1, `req1_ready`=0, `fifo_write_en`=0, `beat_cnt` frozen. Read one entry -> the write resumes with the held data, and no 0xAA-style extra beat appears.
- **Tie priority:** both raise valid together from IDLE after reset -> req0 is granted first. Repeat after req0 was last owner -> req1 is granted first.
- **Early release:** req0 drops valid after 2 beats while req1 is valid -> `grant` goes from 01 to 10 on the next edge with no IDLE cycle. Then req1 drops valid -> IDLE, `grant`=00.
- **Reset mid-burst:** pulse `reset` low during OWN1 beat 2 -> outputs go to 0 immediately. After release, `grant`=00 until a valid is seen, and req0 wins a tie.
